// File: rtl/deperf_sync_ctrl.sv
// ---------------------------------------------------------------------------
// deperf_sync_ctrl
//
// Branch-synchronisation controller for the rate-1/2 deperforator. Decoder
// error/backtrack events are counted over windows of WIN_LEN valid symbols.
// A bad window (errors >= ERR_TH) while searching, or UNLOCK_WINS consecutive
// bad windows while locked, or an i_resync request, produces a slip: a
// one-cycle pulse on o_sh_pointer/o_dec_flush, followed by a settle period
// of SETTLE_LEN valid symbols before evaluation resumes. LOCK_WINS
// consecutive good windows while searching declare lock.
//
// Optional feature: define DEPERF_SYNC_STATS_EN to add the saturating slip
// counter output o_slip_cnt (cleared only by reset).
//
// Ports
//   clk          : clock
//   reset_n      : asynchronous active-low reset
//   i_en         : controller enable (0 = return to SEARCH, clear counters)
//   i_vld        : symbol strobe shared with the deperforator
//   i_dec_err    : decoder error/backtrack event, one count per cycle high
//   i_resync     : forced slip request (ignored while settling)
//   o_sh_pointer : slip pulse to the deperforator
//   o_dec_flush  : decoder flush pulse, coincident with o_sh_pointer
//   o_phase      : mirror of the deperforator phase flag
//   o_locked     : alignment locked
//   o_slip_cnt   : total slips (DEPERF_SYNC_STATS_EN only)
// ---------------------------------------------------------------------------
module deperf_sync_ctrl #(
    parameter int unsigned WIN_LEN     = 256,
    parameter int unsigned ERR_TH      = 16,
    parameter int unsigned SETTLE_LEN  = 64,
    parameter int unsigned LOCK_WINS   = 4,
    parameter int unsigned UNLOCK_WINS = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic             i_dec_err,
    input  logic             i_resync,
    output logic             o_sh_pointer,
    output logic             o_dec_flush,
    output logic             o_phase,
    output logic             o_locked
`ifdef DEPERF_SYNC_STATS_EN
    ,
    output logic [CNT_W-1:0] o_slip_cnt
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WINS - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_WINS - 1);
    localparam logic [CNT_W:0]   ERR_THR     = (CNT_W + 1)'(ERR_TH);

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    logic [CNT_W:0]   err_sum;
    logic             win_end;
    logic             win_bad;
    logic             settle_done;
    logic             resync_req;
    logic             slip;
    logic             lock_acq;

    logic             pulse_next;
    logic             locked_next;

    // Window evaluation includes the error strobe of the window-end cycle.
    assign err_sum     = {1'b0, err_cnt} + {{CNT_W{1'b0}}, i_dec_err};
    assign win_end     = (state != SETTLE) && i_vld && (win_cnt == WIN_LAST);
    assign win_bad     = (err_sum >= ERR_THR);
    assign settle_done = (state == SETTLE) && i_vld && (settle_cnt == SETTLE_LAST);
    assign resync_req  = i_resync && (state != SETTLE);

    // A resync that lands on a window end wins; the window is not evaluated.
    assign slip = i_en && (resync_req ||
                  (win_end && win_bad && (state == SEARCH)) ||
                  (win_end && win_bad && (state == LOCKED) && (bad_cnt == UNLOCK_LAST)));

    assign lock_acq = i_en && !resync_req && (state == SEARCH) &&
                      win_end && !win_bad && (good_cnt == LOCK_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (!i_en) begin
            state_next = SEARCH;
        end else if (slip) begin
            state_next = SETTLE;
        end else begin
            unique case (state)
                SEARCH:  if (lock_acq) state_next = LOCKED;
                SETTLE:  if (settle_done) state_next = SEARCH;
                LOCKED:  state_next = LOCKED;
                default: state_next = SEARCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (next values; registered below)
    // ------------------------------------------------------------------
    always_comb begin
        pulse_next  = slip;
        locked_next = o_locked;
        if (!i_en || slip) begin
            locked_next = 1'b0;
        end else if (lock_acq) begin
            locked_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sh_pointer <= 1'b0;
            o_dec_flush  <= 1'b0;
            o_phase      <= 1'b0;
            o_locked     <= 1'b0;
            win_cnt      <= '0;
            err_cnt      <= '0;
            settle_cnt   <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            o_sh_pointer <= pulse_next;
            o_dec_flush  <= pulse_next;
            // The deperforator toggles its phase on the edge that ends the
            // pulse, even if the controller is disabled during that cycle.
            o_phase      <= o_phase ^ o_sh_pointer;
            o_locked     <= locked_next;

            if (!i_en || slip) begin
                win_cnt    <= '0;
                err_cnt    <= '0;
                settle_cnt <= '0;
                good_cnt   <= '0;
                bad_cnt    <= '0;
            end else if (state == SETTLE) begin
                win_cnt <= '0;
                err_cnt <= '0;
                if (i_vld) begin
                    settle_cnt <= settle_done ? '0 : settle_cnt + CNT_W'(1);
                end
            end else begin
                settle_cnt <= '0;
                if (win_end) begin
                    win_cnt <= '0;
                    err_cnt <= '0;
                    if (state == SEARCH) begin
                        good_cnt <= lock_acq ? '0 : good_cnt + CNT_W'(1);
                    end else if (win_bad) begin
                        bad_cnt <= bad_cnt + CNT_W'(1);
                    end else begin
                        bad_cnt <= '0;
                    end
                end else begin
                    if (i_vld) begin
                        win_cnt <= win_cnt + CNT_W'(1);
                    end
                    if (i_dec_err && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef DEPERF_SYNC_STATS_EN
    // Slip statistics survive disables; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_slip_cnt <= '0;
        end else if (slip && (o_slip_cnt != '1)) begin
            o_slip_cnt <= o_slip_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_deperf_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_deperf_sync_ctrl
//
// Directed bench for deperf_sync_ctrl with WIN_LEN=8, ERR_TH=2, SETTLE_LEN=4,
// LOCK_WINS=4, UNLOCK_WINS=2. A behavioural reference model pushes the
// expected outputs of every cycle into a queue as inputs are driven; they are
// popped and compared once the clock edge has produced the DUT outputs.
// Hand-derived cycle-exact checks supplement the model. Compile with
// DEPERF_SYNC_STATS_EN to include o_slip_cnt.
// ---------------------------------------------------------------------------
module tb_deperf_sync_ctrl;

    localparam int unsigned WL = 8;
    localparam int unsigned ET = 2;
    localparam int unsigned SL = 4;
    localparam int unsigned LW = 4;
    localparam int unsigned UW = 2;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic vld;
    logic derr;
    logic resync;
    logic sh;
    logic flush;
    logic phase;
    logic locked;
`ifdef DEPERF_SYNC_STATS_EN
    logic [CW-1:0] slip_cnt;
`endif

    always #5 clk = ~clk;

    deperf_sync_ctrl #(
        .WIN_LEN    (WL),
        .ERR_TH     (ET),
        .SETTLE_LEN (SL),
        .LOCK_WINS  (LW),
        .UNLOCK_WINS(UW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_en        (en),
        .i_vld       (vld),
        .i_dec_err   (derr),
        .i_resync    (resync),
        .o_sh_pointer(sh),
        .o_dec_flush (flush),
        .o_phase     (phase),
        .o_locked    (locked)
`ifdef DEPERF_SYNC_STATS_EN
        ,
        .o_slip_cnt  (slip_cnt)
`endif
    );

    typedef struct {
        logic sh;
        logic flush;
        logic phase;
        logic locked;
        int   slips;
    } exp_t;

    exp_t sb[$];

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int sh_seen = 0;
    int sh0     = 0;

    // Reference model state: 0 = search, 1 = settle, 2 = locked
    int   m_state;
    int   m_win;
    int   m_err;
    int   m_settle;
    int   m_good;
    int   m_bad;
    int   m_slips;
    logic m_sh;
    logic m_phase;
    logic m_locked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_win    = 0;
        m_err    = 0;
        m_settle = 0;
        m_good   = 0;
        m_bad    = 0;
        m_slips  = 0;
        m_sh     = 1'b0;
        m_phase  = 1'b0;
        m_locked = 1'b0;
    endtask

    // Advances the model by one clock edge given this cycle's inputs.
    task automatic model_step(input logic e, input logic v, input logic d, input logic r);
        logic nphase;
        logic nsh;
        logic nlock;
        logic doslip;
        int   errs;
        nphase = m_phase ^ m_sh;
        nsh    = 1'b0;
        nlock  = m_locked;
        doslip = 1'b0;
        if (!e) begin
            m_state = 0; m_win = 0; m_err = 0; m_settle = 0; m_good = 0; m_bad = 0;
            nlock = 1'b0;
        end else if (m_state == 1) begin
            m_err = 0;
            if (v) begin
                m_settle++;
                if (m_settle == SL) begin
                    m_state  = 0;
                    m_settle = 0;
                end
            end
        end else begin
            errs = m_err + (d ? 1 : 0);
            if (r) begin
                doslip = 1'b1;
            end else if (v && (m_win + 1 == WL)) begin
                if (m_state == 0) begin
                    if (errs >= ET) doslip = 1'b1;
                    else begin
                        m_good++;
                        if (m_good == LW) begin
                            m_state = 2;
                            nlock   = 1'b1;
                            m_good  = 0;
                        end
                    end
                end else begin
                    if (errs >= ET) begin
                        m_bad++;
                        if (m_bad == UW) doslip = 1'b1;
                    end else begin
                        m_bad = 0;
                    end
                end
                m_win = 0;
                m_err = 0;
            end else begin
                if (v) m_win++;
                m_err = errs;
            end
            if (doslip) begin
                nsh = 1'b1;
                nlock = 1'b0;
                m_state = 1; m_win = 0; m_err = 0; m_settle = 0; m_good = 0; m_bad = 0;
                m_slips++;
            end
        end
        m_sh     = nsh;
        m_phase  = nphase;
        m_locked = nlock;
    endtask

    task automatic step(input logic e, input logic v, input logic d, input logic r);
        exp_t x;
        en = e; vld = v; derr = d; resync = r;
        model_step(e, v, d, r);
        x.sh = m_sh; x.flush = m_sh; x.phase = m_phase; x.locked = m_locked; x.slips = m_slips;
        sb.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        x = sb.pop_front();
        chk("sh_pointer", {31'b0, sh}, {31'b0, x.sh});
        chk("dec_flush", {31'b0, flush}, {31'b0, x.flush});
        chk("phase", {31'b0, phase}, {31'b0, x.phase});
        chk("locked", {31'b0, locked}, {31'b0, x.locked});
`ifdef DEPERF_SYNC_STATS_EN
        chk("slip_cnt", {16'b0, slip_cnt}, x.slips);
`endif
        if (sh === 1'b1) sh_seen++;
    endtask

    task automatic run(input int n, input logic v, input logic d);
        for (int i = 0; i < n; i++) step(1'b1, v, d, 1'b0);
    endtask

    // One window of WL valid symbols.
    // mode 0: clean; 1: errors on first and last symbol (bad);
    // 2: as 1 plus resync on the last symbol; 3: single error on last (good).
    task automatic win(input int mode);
        for (int i = 0; i < int'(WL); i++) begin
            step(1'b1, 1'b1,
                 ((mode == 1 || mode == 2) && i == 0) || (mode != 0 && i == int'(WL) - 1),
                 (mode == 2) && (i == int'(WL) - 1));
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        en = 1'b1; vld = 1'b0; derr = 1'b0; resync = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_sh", {31'b0, sh}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_phase", {31'b0, phase}, 32'd0);
        chk("rst_locked", {31'b0, locked}, 32'd0);
`ifdef DEPERF_SYNC_STATS_EN
        chk("rst_slip_cnt", {16'b0, slip_cnt}, 32'd0);
`endif
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        sh_seen = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; vld = 1'b0; derr = 1'b0; resync = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Clean continuous run: lock visible during cycle 33, no slips.
        do_reset();
        run(31, 1'b1, 1'b0);
        chk("s1_prelock", {31'b0, locked}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s1_lock33", {31'b0, locked}, 32'd1);
        chk("s1_noslip", sh_seen, 32'd0);

        // Three errors in the first window: pulse in cycle 9, phase from 10.
        do_reset();
        run(3, 1'b1, 1'b1);
        run(4, 1'b1, 1'b0);
        chk("s2_nopulse8", {31'b0, sh}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2_pulse9", {31'b0, sh}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2_phase10", {31'b0, phase}, 32'd1);
        chk("s2_pulse_once", {31'b0, sh}, 32'd0);
        // Settle covers cycles 9..12, lock windows end at 20/28/36/44.
        run(34, 1'b1, 1'b0);
        chk("s2_prelock", {31'b0, locked}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2_relock45", {31'b0, locked}, 32'd1);
        chk("s2_one_slip", sh_seen, 32'd1);

        // Locked: bad, good, threshold-minus-one good, bad -> no slip.
        sh0 = sh_seen;
        win(1); win(0); win(3); win(1);
        chk("s3_noslip", sh_seen - sh0, 32'd0);
        chk("s3_still_locked", {31'b0, locked}, 32'd1);
        win(1);
        chk("s3_unlock_slip", sh_seen - sh0, 32'd1);
        chk("s3_unlocked", {31'b0, locked}, 32'd0);
`ifdef DEPERF_SYNC_STATS_EN
        chk("s3_slip_cnt", {16'b0, slip_cnt}, 32'd2);
`endif

        // Resync on a bad window end: one pulse. Resync while settling: none.
        run(4, 1'b1, 1'b0);
        sh0 = sh_seen;
        win(2);
        chk("s4_resync_one", sh_seen - sh0, 32'd1);
`ifdef DEPERF_SYNC_STATS_EN
        chk("s4_slip_cnt", {16'b0, slip_cnt}, 32'd3);
`endif
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s4_settle_ignores", sh_seen - sh0, 32'd1);
        chk("s5_phase_pre", {31'b0, phase}, 32'd1);

        // Asynchronous reset mid-settle, then a normal clean lock.
        #2;
        do_reset();
        run(31, 1'b1, 1'b0);
        chk("s5_prelock", {31'b0, locked}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s5_lock", {31'b0, locked}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s5_disable_unlock", {31'b0, locked}, 32'd0);
        run(10, 1'b1, 1'b0);
        chk("s5_no_pulse", sh_seen, 32'd0);

        // Gapped strobe, errors only on idle cycles: the 8th valid symbol is
        // cycle 15, so the window ends there and the slip follows.
        do_reset();
        for (int i = 1; i <= 14; i++) step(1'b1, (i % 2) == 1, (i % 2) == 0, 1'b0);
        chk("s6_no_early_end", sh_seen, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s6_gapped_slip", {31'b0, sh}, 32'd1);
        for (int i = 0; i < 12; i++) step(1'b1, (i % 2) == 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/deperf_sync_ctrl.md
# deperf_sync_ctrl

Branch-synchronisation controller for the rate-1/2 deperforator. Watches the Fano decoder's error/backtrack indications over fixed windows of valid symbols and decides whether the current symbol-pair alignment is wrong. On a wrong alignment it issues a one-cycle slip pulse to the deperforator's `i_sh_pointer` and flushes the decoder. It also reports lock status and the deperforator's current phase.

## Interface
- `WIN_LEN`, 256: valid symbols per evaluation window (≥2)
- `ERR_TH`, 16: decoder errors per window at which the window counts as bad (≥1)
- `SETTLE_LEN`, 64: valid symbols ignored after a slip (≥1)
- `LOCK_WINS`, 4: consecutive good windows needed to declare lock (≥1)
- `UNLOCK_WINS`, 2: consecutive bad windows needed to drop lock (≥1)
- `CNT_W`, 16: width of the internal counters and the stats counter; must hold WIN_LEN, SETTLE_LEN and ERR_TH
- `clk` in 1: clock
- `reset_n` in 1: asynchronous active-low reset
- `i_en` in 1: controller enable
- `i_vld` in 1: symbol strobe, the same strobe that feeds the deperforator `i_vld`
- `i_dec_err` in 1: decoder error/backtrack event, one count per cycle high
- `i_resync` in 1: forced slip request, single-cycle
- `o_sh_pointer` out 1: slip pulse to the deperforator
- `o_dec_flush` out 1: decoder flush pulse, coincident with `o_sh_pointer`
- `o_phase` out 1: mirror of the deperforator's internal phase flag
- `o_locked` out 1: alignment locked
- `o_slip_cnt` out CNT_W: total slips; present only with `DEPERF_SYNC_STATS_EN`

## Operation
- States: SEARCH, SETTLE, LOCKED. Reset state is SEARCH.
- Window counter:
  - Increments on `i_vld`.
  - Window end is the cycle with `i_vld` and counter = WIN_LEN-1. The counter then returns to 0.
- Error counter:
  - Increments on every `i_dec_err` cycle, whether or not `i_vld` is high, and saturates at 2^CNT_W-1.
  - At window end the count includes that cycle's `i_dec_err`. The window is bad if the count ≥ ERR_TH, otherwise good.
  - The error counter clears at window end.
- SEARCH:
  - Good window: good_cnt++. When good_cnt reaches LOCK_WINS, go to LOCKED and set `o_locked`=1.
  - Bad window: slip.
- LOCKED:
  - Good window clears bad_cnt.
  - Bad window: bad_cnt++. When bad_cnt reaches UNLOCK_WINS, slip and set `o_locked`=0.
- Slip (from any state):
  - Pulse `o_sh_pointer` and `o_dec_flush` for one cycle, then go to SETTLE.
  - Clear good_cnt, bad_cnt, the window counter and the error counter. Increment the slip counter, which saturates.
- SETTLE:
  - Counts SETTLE_LEN `i_vld` symbols; the error counter is held at 0.
  - Then go to SEARCH with a fresh window.
- `i_resync`:
  - Causes a slip from SEARCH or LOCKED.
  - Ignored in SETTLE.
  - If it coincides with a window end, it takes priority: exactly one slip, no window evaluation.
- `o_phase` toggles at the clock edge that ends each `o_sh_pointer` pulse. This is the same edge on which the deperforator samples the pulse and toggles its own phase flag.
- `i_en`=0:
  - Go synchronously to SEARCH, clear all counters except the stats counter, and hold all pulses low.
  - `o_phase` and `o_locked` hold their values; a disable while in LOCKED clears `o_locked` to 0.
- Reset, including mid-operation: all outputs 0, state SEARCH, all counters 0. This keeps `o_phase` consistent with the deperforator, which resets its phase flag to 0.

## Timing
- Window end on cycle E gives:
  - `o_sh_pointer` / `o_dec_flush` high during E+1 only.
  - `o_phase` changes after the E+1 edge.
  - `o_locked` changes from E+1.
- `i_resync` on cycle R gives a pulse on R+1.
- After a slip pulse, at least SETTLE_LEN+WIN_LEN valid symbols elapse before the next window-driven slip. An `i_resync` in SEARCH or LOCKED can shorten this.
- All outputs are registered and there are no combinational input-to-output paths.
- The pulse outputs are never high on two consecutive cycles.

## Configuration
- `DEPERF_SYNC_STATS_EN` defined:
  - `o_slip_cnt` port exists.
  - It counts every slip, window-driven or `i_resync`, and saturates at 2^CNT_W-1.
  - It clears only on reset.
- Not defined: the port and counter are absent and the rest of the behaviour is identical.

## Test plan
- WIN_LEN=8, ERR_TH=2, LOCK_WINS=4; continuous `i_vld`, no errors → `o_locked` rises one cycle after the 4th window end (cycle 33 counting from 1); no slips.
- Same configuration, 3 `i_dec_err` in the first window → pulse on cycle 9, `o_phase`=1 from cycle 10, `o_locked`=0; after SETTLE_LEN symbols plus 4 clean windows, lock is acquired.
- Locked with UNLOCK_WINS=2: bad, good, bad windows → no slip. Two consecutive bad windows → slip, `o_locked`=0, `o_slip_cnt` increments by 1.
- `i_resync` on a window-end cycle that is also bad → exactly one pulse and one `o_slip_cnt` increment. `i_resync` during SETTLE → no pulse.
- `reset_n` asserted asynchronously mid-SETTLE → all outputs 0 immediately. After release, a 0-error run locks normally.
- `i_vld` gapped every other cycle with errors on idle cycles → the errors are counted, and window length is measured in valid symbols, not clock cycles.
